// File: rtl/multicycle_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | multicycle_controller: Moore sequencing FSM for a multi-cycle MIPS datapath |
// | Optional feature macro: MC_PERF_COUNTER_EN (cycleCount / instrCount ports)  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module multicycle_controller #(
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic [3:0] state,
  output logic       trap
`ifdef MC_PERF_COUNTER_EN
  ,
  output logic [CNT_WIDTH-1:0] cycleCount,
  output logic [CNT_WIDTH-1:0] instrCount
`endif
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_ERROR  = 4'd15
  } state_t;

  localparam logic [5:0] c_OP_R    = 6'b000000;
  localparam logic [5:0] c_OP_LW   = 6'b100011;
  localparam logic [5:0] c_OP_SW   = 6'b101011;
  localparam logic [5:0] c_OP_BEQ  = 6'b000100;
  localparam logic [5:0] c_OP_J    = 6'b000010;
  localparam logic [5:0] c_OP_ADDI = 6'b001000;
  localparam logic [7:0] c_TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_stateNext;
  logic [7:0] r_waitCnt;
  logic       w_waitState;
  logic       w_timedOut;

  assign w_waitState = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
  // The last permitted low cycle: memReady=1 here still succeeds, low traps.
  assign w_timedOut  = (r_waitCnt == c_TIMEOUT_M1);
  assign state       = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waitCnt <= 8'd0;
    end else if (w_stateNext != r_state) begin
      r_waitCnt <= 8'd0;
    end else if (w_waitState && !memReady) begin
      r_waitCnt <= r_waitCnt + 8'd1;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    IorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    trap        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        if (memReady) begin
          irWrite     = 1'b1;
          pcWrite     = 1'b1;
          w_stateNext = ST_DECODE;
        end else if (w_timedOut) begin
          w_stateNext = ST_ERROR;
        end
      end
      ST_DECODE: begin
        aluSrcB = 2'b11;
        case (opcode)
          c_OP_LW, c_OP_SW: w_stateNext = ST_MEMADR;
          c_OP_R:           w_stateNext = ST_EXEC;
          c_OP_BEQ:         w_stateNext = ST_BRANCH;
          c_OP_J:           w_stateNext = ST_JUMP;
          c_OP_ADDI:        w_stateNext = ST_ADDIEX;
          default:          w_stateNext = ST_ERROR;
        endcase
      end
      ST_MEMADR: begin
        aluSrcA     = 1'b1;
        aluSrcB     = 2'b10;
        w_stateNext = (opcode == c_OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        memRead = 1'b1;
        IorD    = 1'b1;
        if (memReady)        w_stateNext = ST_MEMWB;
        else if (w_timedOut) w_stateNext = ST_ERROR;
      end
      ST_MEMWB: begin
        regWrite    = 1'b1;
        memToReg    = 1'b1;
        w_stateNext = ST_FETCH;
      end
      ST_MEMWR: begin
        memWrite = 1'b1;
        IorD     = 1'b1;
        if (memReady)        w_stateNext = ST_FETCH;
        else if (w_timedOut) w_stateNext = ST_ERROR;
      end
      ST_EXEC: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b10;
        w_stateNext = ST_ALUWB;
      end
      ST_ALUWB: begin
        regWrite    = 1'b1;
        regDst      = 1'b1;
        w_stateNext = ST_FETCH;
      end
      ST_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        w_stateNext = ST_FETCH;
      end
      ST_JUMP: begin
        pcWrite     = 1'b1;
        pcSource    = 2'b10;
        w_stateNext = ST_FETCH;
      end
      ST_ADDIEX: begin
        aluSrcA     = 1'b1;
        aluSrcB     = 2'b10;
        w_stateNext = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        regWrite    = 1'b1;
        w_stateNext = ST_FETCH;
      end
      ST_ERROR: begin
        trap = 1'b1;
      end
      default: w_stateNext = ST_ERROR;
    endcase
    // Async reset must silence every strobe immediately, not at the next edge.
    if (reset) begin
      IorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      regDst      = 1'b0;
      memToReg    = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 2'b00;
      pcSource    = 2'b00;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      trap        = 1'b0;
    end
  end

`ifdef MC_PERF_COUNTER_EN
  logic w_finalState;
  assign w_finalState = (r_state == ST_MEMWB) || (r_state == ST_MEMWR) || (r_state == ST_ALUWB) ||
                        (r_state == ST_BRANCH) || (r_state == ST_JUMP) || (r_state == ST_ADDIWB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCount <= '0;
      instrCount <= '0;
    end else begin
      if (r_state != ST_ERROR) cycleCount <= cycleCount + CNT_WIDTH'(1);
      if (w_finalState && (w_stateNext == ST_FETCH)) instrCount <= instrCount + CNT_WIDTH'(1);
    end
  end
`else
  logic [CNT_WIDTH-1:0] w_unusedCnt;
  assign w_unusedCnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_multicycle_controller: directed vector bench for multicycle_controller   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_multicycle_controller;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // {IorD,memRead,memWrite,irWrite, regDst,memToReg,regWrite,aluSrcA,
  //  aluSrcB,aluOp, pcSource,pcWrite,pcWriteCond,trap}
  localparam logic [16:0] O_FETCH1 = 17'b0101_0000_0100_00100;
  localparam logic [16:0] O_FETCH0 = 17'b0100_0000_0100_00000;
  localparam logic [16:0] O_DECODE = 17'b0000_0000_1100_00000;
  localparam logic [16:0] O_MEMADR = 17'b0000_0001_1000_00000;
  localparam logic [16:0] O_MEMRD  = 17'b1100_0000_0000_00000;
  localparam logic [16:0] O_MEMWB  = 17'b0000_0110_0000_00000;
  localparam logic [16:0] O_MEMWR  = 17'b1010_0000_0000_00000;
  localparam logic [16:0] O_EXEC   = 17'b0000_0001_0010_00000;
  localparam logic [16:0] O_ALUWB  = 17'b0000_1010_0000_00000;
  localparam logic [16:0] O_BRANCH = 17'b0000_0001_0001_01010;
  localparam logic [16:0] O_JUMP   = 17'b0000_0000_0000_10100;
  localparam logic [16:0] O_ADDIWB = 17'b0000_0010_0000_00000;
  localparam logic [16:0] O_ERROR  = 17'b0000_0000_0000_00001;
  localparam logic [16:0] O_NONE   = 17'b0;

  logic clk = 1'b0;
  logic reset, memReady;
  logic [5:0] opcode;
  logic IorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic pcWrite, pcWriteCond, trap;
  logic [3:0] state;
  logic [16:0] outs;
`ifdef MC_PERF_COUNTER_EN
  logic [31:0] cycleCount, instrCount;
`endif

  assign outs = {IorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA,
                 aluSrcB, aluOp, pcSource, pcWrite, pcWriteCond, trap};

  multicycle_controller #(.TIMEOUT(15), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady),
    .IorD(IorD), .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource), .pcWrite(pcWrite),
    .pcWriteCond(pcWriteCond), .state(state), .trap(trap)
`ifdef MC_PERF_COUNTER_EN
    , .cycleCount(cycleCount), .instrCount(instrCount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] out;
  } vec_t;
  vec_t vecs[$];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkCycle(input string name, input logic [3:0] st, input logic [16:0] o);
    checkVal({name, " state"}, 32'(state), 32'(st));
    checkVal({name, " outs"}, 32'(outs), 32'(o));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench mid-cycle with reset released and the FSM in FETCH.
  task automatic doReset();
    reset = 1'b1;
    #1;
    checkCycle("reset", 4'd0, O_NONE);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive(input logic [5:0] op, input logic mr);
    opcode   = op;
    memReady = mr;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    opcode = OP_R;
    memReady = 1'b0;

    vecs.push_back('{OP_R,    1'b1, 4'd0,  O_FETCH1});
    vecs.push_back('{OP_R,    1'b1, 4'd1,  O_DECODE});
    vecs.push_back('{OP_R,    1'b1, 4'd6,  O_EXEC});
    vecs.push_back('{OP_R,    1'b1, 4'd7,  O_ALUWB});
    vecs.push_back('{OP_BEQ,  1'b1, 4'd0,  O_FETCH1});
    vecs.push_back('{OP_BEQ,  1'b1, 4'd1,  O_DECODE});
    vecs.push_back('{OP_BEQ,  1'b1, 4'd8,  O_BRANCH});
    vecs.push_back('{OP_J,    1'b1, 4'd0,  O_FETCH1});
    vecs.push_back('{OP_J,    1'b1, 4'd1,  O_DECODE});
    vecs.push_back('{OP_J,    1'b1, 4'd9,  O_JUMP});
    vecs.push_back('{OP_ADDI, 1'b1, 4'd0,  O_FETCH1});
    vecs.push_back('{OP_ADDI, 1'b1, 4'd1,  O_DECODE});
    vecs.push_back('{OP_ADDI, 1'b1, 4'd10, O_MEMADR});
    vecs.push_back('{OP_ADDI, 1'b1, 4'd11, O_ADDIWB});
    vecs.push_back('{OP_SW,   1'b1, 4'd0,  O_FETCH1});
    vecs.push_back('{OP_SW,   1'b1, 4'd1,  O_DECODE});
    vecs.push_back('{OP_SW,   1'b1, 4'd2,  O_MEMADR});
    vecs.push_back('{OP_SW,   1'b1, 4'd5,  O_MEMWR});
    vecs.push_back('{OP_LW,   1'b1, 4'd0,  O_FETCH1});
    vecs.push_back('{OP_LW,   1'b1, 4'd1,  O_DECODE});
    vecs.push_back('{OP_LW,   1'b1, 4'd2,  O_MEMADR});
    vecs.push_back('{OP_LW,   1'b1, 4'd3,  O_MEMRD});
    vecs.push_back('{OP_LW,   1'b1, 4'd4,  O_MEMWB});
    vecs.push_back('{OP_R,    1'b1, 4'd0,  O_FETCH1});

    doReset();

    // Back-to-back instruction stream with memReady always high.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].mr);
      checkCycle($sformatf("vec%0d", i), vecs[i].st, vecs[i].out);
      if (i != vecs.size() - 1) step();
    end

    // LW with three wait cycles in MEMRD: 8 cycles FETCH to FETCH.
    doReset();
    drive(OP_LW, 1'b1); checkCycle("lwWait fetch", 4'd0, O_FETCH1); step();
    drive(OP_LW, 1'b1); checkCycle("lwWait decode", 4'd1, O_DECODE); step();
    drive(OP_LW, 1'b1); checkCycle("lwWait memadr", 4'd2, O_MEMADR); step();
    for (int i = 0; i < 3; i++) begin
      drive(OP_LW, 1'b0);
      checkCycle($sformatf("lwWait memrd%0d", i), 4'd3, O_MEMRD);
      step();
    end
    drive(OP_LW, 1'b1); checkCycle("lwWait memrdGo", 4'd3, O_MEMRD); step();
    drive(OP_LW, 1'b0); checkCycle("lwWait memwb", 4'd4, O_MEMWB); step();
    drive(OP_R, 1'b0); checkCycle("lwWait back", 4'd0, O_FETCH0);

    // Illegal opcode traps, memReady is ignored, reset recovers.
    doReset();
    drive(OP_BAD, 1'b1); step();
    drive(OP_BAD, 1'b1); checkCycle("illegal decode", 4'd1, O_DECODE); step();
    for (int i = 0; i < 4; i++) begin
      drive(OP_R, 1'(i));
      checkCycle($sformatf("illegal err%0d", i), 4'd15, O_ERROR);
      step();
    end
    doReset();
    drive(OP_R, 1'b0); checkCycle("illegal recovered", 4'd0, O_FETCH0);

    // Fifteen low cycles in FETCH trap.
    doReset();
    for (int i = 0; i < 15; i++) begin
      drive(OP_R, 1'b0);
      if (i == 0 || i == 14) checkCycle($sformatf("timeout fetch%0d", i), 4'd0, O_FETCH0);
      step();
    end
    drive(OP_R, 1'b1); checkCycle("timeout err", 4'd15, O_ERROR);

    // Fourteen low cycles then memReady on the fifteenth succeeds.
    doReset();
    for (int i = 0; i < 14; i++) begin
      drive(OP_R, 1'b0);
      step();
    end
    drive(OP_R, 1'b1); checkCycle("edge fetchGo", 4'd0, O_FETCH1); step();
    drive(OP_R, 1'b1); checkCycle("edge decode", 4'd1, O_DECODE);

    // Reset mid-LW aborts immediately, even with memRead pending.
    doReset();
    drive(OP_LW, 1'b1); step();
    drive(OP_LW, 1'b1); step();
    drive(OP_LW, 1'b0); step();
    drive(OP_LW, 1'b0); checkCycle("midLw memrd", 4'd3, O_MEMRD);
    reset = 1'b1;
    #1;
    checkCycle("midLw reset", 4'd0, O_NONE);
    @(negedge clk);
    reset = 1'b0;

`ifdef MC_PERF_COUNTER_EN
    doReset();
    checkVal("perf cycle0", cycleCount, 32'd0);
    checkVal("perf instr0", instrCount, 32'd0);
    for (int i = 0; i < 4; i++) begin drive(OP_R, 1'b1); step(); end
    for (int i = 0; i < 5; i++) begin drive(OP_LW, 1'b1); step(); end
    for (int i = 0; i < 4; i++) begin drive(OP_SW, 1'b1); step(); end
    for (int i = 0; i < 3; i++) begin drive(OP_BEQ, 1'b1); step(); end
    checkVal("perf instr", instrCount, 32'd4);
    checkVal("perf cycle", cycleCount, 32'd16);
    checkVal("perf state", 32'(state), 32'd0);
    drive(OP_LW, 1'b1); step();
    drive(OP_LW, 1'b1); step();
    drive(OP_LW, 1'b0); step();
    reset = 1'b1;
    #1;
    checkVal("perf rstCycle", cycleCount, 32'd0);
    checkVal("perf rstInstr", instrCount, 32'd0);
    checkVal("perf rstState", 32'(state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style sequencing FSM for the multi-cycle MIPS datapath.
- Shares one unified instruction/data memory, ALU and PC adder across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK cycles.
- Drives every datapath mux select and write strobe.
- Waits on a memory-ready handshake and traps illegal opcodes and memory timeouts.

Parameters:
- TIMEOUT, 15: max cycles spent waiting for memReady in one memory state before trapping; range 1..255.
- CNT_WIDTH, 32: width of performance counters (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction bits [31:26] from the instruction register.
- memReady  input  1  memory completes the current access this cycle.
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- memRead  output  1  memory read request.
- memWrite  output  1  memory write request.
- irWrite  output  1  instruction register load.
- regDst  output  1  write register select: 0=rt, 1=rd.
- memToReg  output  1  writeback select: 0=ALUOut, 1=MDR.
- regWrite  output  1  register file write.
- aluSrcA  output  1  0=PC, 1=rs.
- aluSrcB  output  2  00=rt, 01=const 4, 10=signext, 11=signext<<2.
- aluOp  output  2  00=add, 01=sub, 10=funct-decoded.
- pcSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- pcWrite  output  1  unconditional PC load.
- pcWriteCond  output  1  PC load if zero (datapath ANDs with zero).
- state  output  4  current state code.
- trap  output  1  sticky error flag.

Behaviour:
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, J=000010, ADDI=001000. Any other opcode is illegal.
- State codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, ERROR=15
- Reset: state=FETCH, wait counter=0, trap=0. While reset is high, all strobes (memRead, memWrite, irWrite, regWrite, pcWrite, pcWriteCond) are forced 0 and all selects are 0.
- FETCH:
  - Outputs: memRead=1, IorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite and pcWrite are asserted only in the cycle memReady=1.
  - Advances to DECODE on that edge; otherwise holds.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target precompute). Next state:
  - LW/SW → MEMADR
  - R → EXEC
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDIEX
  - illegal → ERROR
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Next: LW → MEMRD, SW → MEMWR.
- MEMRD: memRead=1, IorD=1. Holds until memReady; then → MEMWB.
- MEMWB: regWrite=1, regDst=0, memToReg=1 → FETCH.
- MEMWR: memWrite=1, IorD=1. Holds until memReady; then → FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10 → ALUWB.
- ALUWB: regWrite=1, regDst=1, memToReg=0 → FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01 → FETCH.
- JUMP: pcWrite=1, pcSource=10 → FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00 → ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0 → FETCH.
- Latency per instruction, in cycles, with memReady always 1:
  - LW 5; SW 4; R 4; ADDI 4; BEQ 3; J 3.
  - Each extra memReady-low cycle adds 1.
- Wait counter:
  - Cleared on entry to FETCH/MEMRD/MEMWR; increments each cycle memReady=0 in those states.
  - If the counter reaches TIMEOUT with memReady still 0 → ERROR.
  - memReady=1 in the same cycle as the counter hits TIMEOUT counts as success.
- ERROR: all strobes 0, trap=1. Sticky until reset.
- memReady is ignored outside FETCH/MEMRD/MEMWR.
- Reset asserted mid-instruction aborts immediately; no partial writes occur after reset is asserted.

Optional Feature:
- Macro MC_PERF_COUNTER_EN.
- Defined: adds outputs cycleCount and instrCount (both CNT_WIDTH).
  - cycleCount increments every non-reset cycle except in ERROR.
  - instrCount increments on each transition into FETCH from a final state (MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB).
  - Both wrap modulo 2^CNT_WIDTH and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then opcode=000000, memReady=1 → state sequence 0,1,6,7,0. regWrite=1 with regDst=1 in state 7 only. irWrite/pcWrite pulse once in state 0.
- LW (100011), memReady held 0 for 3 cycles in MEMRD → stays in state 3 for 4 cycles, memRead=1, IorD=1 throughout. Then 4, regWrite=1, memToReg=1. Total 8 cycles.
- BEQ (000100) then J (000010) → 0,1,8,0: pcWriteCond=1, aluOp=01, pcSource=01 in state 8. Then 0,1,9,0: pcWrite=1, pcSource=10 in state 9.
- Illegal opcode 111111 → DECODE → 15, trap=1; memReady toggling has no effect. Reset returns to state 0 with trap=0.
- memReady=0 for TIMEOUT=15 cycles in FETCH → ERROR, trap=1. Repeat with memReady=1 on the 15th wait cycle → advances to DECODE with no trap.
- With MC_PERF_COUNTER_EN: run R, LW, SW, BEQ with memReady=1 → instrCount=4, cycleCount=16. Assert reset mid-LW → both counters 0 and state 0 immediately.
